// File: rtl/freq_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_counter_pkg
// Description : Shared widths, display limit, FSM state encoding and the
//               saturation helper for the gated edge counter.
// Revision    : 1.0  initial release
// ============================================================================
package freq_counter_pkg;

   localparam int NB_W     = 14;
   localparam int DISP_MAX = 9999;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } fc_state_e;

   // Clamp a 15-bit running total to the display limit
   function automatic logic [NB_W-1:0] sat_count(input logic [NB_W:0]   v,
                                                 input logic [NB_W-1:0] lim);
      return (v > {1'b0, lim}) ? lim : v[NB_W-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/freq_counter_sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_det
// Description : Multi-flop synchronizer for an asynchronous input followed
//               by a rising-edge detector on the synchronized level.
// Revision    : 1.0  initial release
// ============================================================================
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic myclk,
   input  logic rst,
   input  logic sig_in,
   output logic s,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   // Next-state: shift the raw input in, remember last synchronized level
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   // Synchronizer and history flops; prev tracks s in every cycle
   always_ff @(posedge myclk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/freq_counter.sv
`default_nettype none
// ============================================================================
// Module      : freq_counter
// Description : Gated edge counter. Counts rising edges of sig_in over a
//               GATE_CYCLES window and publishes a saturated 14-bit result
//               with an overflow flag and a one-cycle valid strobe.
// Revision    : 1.0  initial release
// ============================================================================
module freq_counter
   import freq_counter_pkg::*;
#(
   parameter int GATE_CYCLES = 100_000_000,
   parameter int MAX_COUNT   = 9999,
   parameter int SYNC_STAGES = 2
) (
   input  logic            myclk,
   input  logic            rst,
   input  logic            enable,
   input  logic            sig_in,
   output logic [NB_W-1:0] nb,
   output logic            ovf,
   output logic            valid
);

   localparam int              GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [NB_W-1:0]   CNT_MAX   = NB_W'(MAX_COUNT);

   fc_state_e         state_q, state_d;
   logic [NB_W-1:0]   count_q, count_d;
   logic [GATE_W-1:0] gate_q, gate_d;
   logic              ovf_pend_q, ovf_pend_d;
   logic [NB_W-1:0]   nb_q, nb_d;
   logic              ovf_q, ovf_d;
   logic              valid_q, valid_d;

   logic              rise;
   logic              sync_s_unused;
   logic [NB_W:0]     sum;
   logic              at_max;

   sync_edge_det #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .myclk  (myclk),
      .rst    (rst),
      .sig_in (sig_in),
      .s      (sync_s_unused),
      .rise   (rise)
   );

   // Window FSM: gate counting, saturating edge count and result publish
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      gate_d     = gate_q;
      ovf_pend_d = ovf_pend_q;
      nb_d       = nb_q;
      ovf_d      = ovf_q;
      valid_d    = 1'b0;

      // An edge in the closing cycle still belongs to this window, so the
      // published value is the count plus the current edge, clamped.
      sum    = {1'b0, count_q} + {{NB_W{1'b0}}, rise};
      at_max = rise && (count_q == CNT_MAX);

      case (state_q)
         ST_IDLE: begin
            count_d    = '0;
            gate_d     = '0;
            ovf_pend_d = 1'b0;
            if (enable) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!enable) begin
               // Abort discards the partial window, even in its last cycle
               state_d    = ST_IDLE;
               count_d    = '0;
               gate_d     = '0;
               ovf_pend_d = 1'b0;
            end else if (gate_q == GATE_LAST) begin
               nb_d       = sat_count(sum, CNT_MAX);
               ovf_d      = ovf_pend_q | at_max;
               valid_d    = 1'b1;
               count_d    = '0;
               gate_d     = '0;
               ovf_pend_d = 1'b0;
            end else begin
               gate_d = gate_q + GATE_W'(1);
               if (at_max)    ovf_pend_d = 1'b1;
               else if (rise) count_d    = sum[NB_W-1:0];
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge myclk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         gate_q     <= '0;
         ovf_pend_q <= 1'b0;
         nb_q       <= '0;
         ovf_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         gate_q     <= gate_d;
         ovf_pend_q <= ovf_pend_d;
         nb_q       <= nb_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
      end
   end

   assign nb    = nb_q;
   assign ovf   = ovf_q;
   assign valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_freq_counter
// Description : Self-checking bench for freq_counter. Two instances share
//               stimulus: one with the display limit, one with a small limit
//               to exercise saturation. A window-level reference model is
//               compared every cycle; segment tables and hand sequences add
//               fixed expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_freq_counter;

   localparam int GATE  = 20;
   localparam int MAX_A = 9999;
   localparam int MAX_B = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        sig_in = 1'b0;
   logic [13:0] nb_a, nb_b;
   logic        ovf_a, ovf_b, valid_a, valid_b;

   int n_vec = 0;
   int n_err = 0;
   int gcyc  = 0;
   bit done  = 1'b0;

   always #5 clk = ~clk;

   freq_counter #(.GATE_CYCLES(GATE), .MAX_COUNT(MAX_A), .SYNC_STAGES(2)) dut_a (
      .myclk(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
      .nb(nb_a), .ovf(ovf_a), .valid(valid_a));

   freq_counter #(.GATE_CYCLES(GATE), .MAX_COUNT(MAX_B), .SYNC_STAGES(2)) dut_b (
      .myclk(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
      .nb(nb_b), .ovf(ovf_b), .valid(valid_b));

   // Reference model: raw edge total per window, clamped only when published
   typedef struct {
      bit [1:0] sh;
      bit       prev;
      bit       running;
      int       pos;
      int       cnt;
      int       nb;
      bit       ovf;
      bit       valid;
   } mdl_t;

   mdl_t m_a = '{default: 0};
   mdl_t m_b = '{default: 0};

   function automatic mdl_t model_next(mdl_t m, int maxc, bit r, bit e, bit si);
      mdl_t n = m;
      bit   s, ed;
      if (r) begin
         n = '{default: 0};
         return n;
      end
      s       = m.sh[1];
      ed      = s && !m.prev;
      n.prev  = s;
      n.sh    = {m.sh[0], si};
      n.valid = 1'b0;
      if (!m.running) begin
         if (e) begin
            n.running = 1'b1;
            n.pos     = 0;
            n.cnt     = 0;
         end
      end else if (!e) begin
         n.running = 1'b0;
      end else begin
         n.cnt = m.cnt + int'(ed);
         n.pos = m.pos + 1;
         if (n.pos == GATE) begin
            n.nb    = (n.cnt > maxc) ? maxc : n.cnt;
            n.ovf   = (n.cnt > maxc);
            n.valid = 1'b1;
            n.pos   = 0;
            n.cnt   = 0;
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      m_a = model_next(m_a, MAX_A, rst, enable, sig_in);
      m_b = model_next(m_b, MAX_B, rst, enable, sig_in);
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (!done) begin
         n_vec++;
         if ({nb_a, ovf_a, valid_a} !== {14'(m_a.nb), m_a.ovf, m_a.valid}) begin
            n_err++;
            $display("FAIL model_a t=%0t act nb=%0d ovf=%0b valid=%0b exp nb=%0d ovf=%0b valid=%0b",
                     $time, nb_a, ovf_a, valid_a, m_a.nb, m_a.ovf, m_a.valid);
         end
         n_vec++;
         if ({nb_b, ovf_b, valid_b} !== {14'(m_b.nb), m_b.ovf, m_b.valid}) begin
            n_err++;
            $display("FAIL model_b t=%0t act nb=%0d ovf=%0b valid=%0b exp nb=%0d ovf=%0b valid=%0b",
                     $time, nb_b, ovf_b, valid_b, m_b.nb, m_b.ovf, m_b.valid);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s t=%0t act=%0d exp=%0d", name, $time, act, exp);
      end
   endtask

   // period: 0 low, 1 high, >=2 square wave, <0 random
   function automatic bit sig_val(int p);
      if (p < 0)  return 1'($urandom_range(0, 1));
      if (p == 0) return 1'b0;
      if (p == 1) return 1'b1;
      return (gcyc % p) < (p / 2);
   endfunction

   task automatic run(input bit r, input bit e, input int period, input int n, output int nv);
      nv = 0;
      for (int i = 0; i < n; i++) begin
         rst    = r;
         enable = e;
         sig_in = sig_val(period);
         @(posedge clk);
         @(negedge clk);
         if (valid_a) nv++;
         gcyc++;
      end
   endtask

   typedef struct {
      bit rst;
      bit en;
      int period;
      int n;
      int nb_a;
      bit ovf_a;
      int nb_b;
      bit ovf_b;
      int nvalid;
      bit vlast;
   } seg_t;

   seg_t segs[12];

   initial begin
      int  nv;
      bit  re;
      bit  ee;

      segs[0]  = '{1'b1, 1'b1, 2, 5,  0,  1'b0, 0, 1'b0, 0, 1'b0}; // reset held
      segs[1]  = '{1'b0, 1'b1, 4, 61, 5,  1'b0, 5, 1'b0, 3, 1'b1}; // period 4
      segs[2]  = '{1'b0, 1'b1, 2, 40, 10, 1'b0, 7, 1'b1, 2, 1'b1}; // period 2, B saturates
      segs[3]  = '{1'b0, 1'b1, 5, 40, 4,  1'b0, 4, 1'b0, 2, 1'b1}; // ovf clears
      segs[4]  = '{1'b0, 1'b0, 4, 10, 4,  1'b0, 4, 1'b0, 0, 1'b0}; // idle holds
      segs[5]  = '{1'b0, 1'b1, 4, 11, 4,  1'b0, 4, 1'b0, 0, 1'b0}; // partial window
      segs[6]  = '{1'b0, 1'b0, 4, 5,  4,  1'b0, 4, 1'b0, 0, 1'b0}; // abort at gate 10
      segs[7]  = '{1'b0, 1'b1, 4, 21, 5,  1'b0, 5, 1'b0, 1, 1'b1}; // 21-cycle latency
      segs[8]  = '{1'b0, 1'b1, 4, 13, 5,  1'b0, 5, 1'b0, 0, 1'b0}; // into window
      segs[9]  = '{1'b1, 1'b1, 4, 1,  0,  1'b0, 0, 1'b0, 0, 1'b0}; // reset mid-window
      segs[10] = '{1'b0, 1'b0, 4, 5,  0,  1'b0, 0, 1'b0, 0, 1'b0}; // no publish
      segs[11] = '{1'b0, 1'b1, 4, 21, 5,  1'b0, 5, 1'b0, 1, 1'b1}; // restart

      for (int k = 0; k < 12; k++) begin
         run(segs[k].rst, segs[k].en, segs[k].period, segs[k].n, nv);
         check($sformatf("seg%0d_nb_a", k),   int'(nb_a),    segs[k].nb_a);
         check($sformatf("seg%0d_ovf_a", k),  int'(ovf_a),   int'(segs[k].ovf_a));
         check($sformatf("seg%0d_nb_b", k),   int'(nb_b),    segs[k].nb_b);
         check($sformatf("seg%0d_ovf_b", k),  int'(ovf_b),   int'(segs[k].ovf_b));
         check($sformatf("seg%0d_nvalid", k), nv,            segs[k].nvalid);
         check($sformatf("seg%0d_vlast", k),  int'(valid_a), int'(segs[k].vlast));
      end

      // Single edge landing in the last window cycle, then an edge-free window
      run(1'b1, 1'b0, 0, 2, nv);
      run(1'b0, 1'b0, 0, 3, nv);
      run(1'b0, 1'b1, 0, 18, nv);
      check("lastcyc_no_early_valid", nv, 0);
      run(1'b0, 1'b1, 1, 3, nv);
      check("lastcyc_valid", int'(valid_a), 1);
      check("lastcyc_nb", int'(nb_a), 1);
      run(1'b0, 1'b1, 1, 20, nv);
      check("quiet_valid", int'(valid_a), 1);
      check("quiet_nb", int'(nb_a), 0);
      check("quiet_ovf_b", int'(ovf_b), 0);

      // Randomized traffic with occasional reset and enable changes
      ee = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         re = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 59) == 0) ee = !ee;
         run(re, ee, -1, 1, nv);
      end

      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
